multdiv_unit: RTL
=================

# multdiv_unit

Sequential signed 32-bit multiply/divide unit for the execute stage. It accepts a one-cycle start command with two operands, iterates radix-2 for a fixed 32 cycles, then presents a 32-bit result, an exception flag and a one-cycle ready strobe. The execute/writeback logic captures that result into the destination 32-bit register while the pipeline is stalled.

## Interface
Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration count; fixed, equal to WIDTH.

Ports:
- clk  in  1  rising-edge clock (single clock domain)
- reset  in  1  synchronous, active-high; clears all state on the next rising edge of clk
- data_operandA  in  32  multiplicand / dividend, two's complement
- data_operandB  in  32  multiplier / divisor, two's complement
- ctrl_MULT  in  1  start-multiply strobe, sampled each edge
- ctrl_DIV  in  1  start-divide strobe, sampled each edge
- data_result  out  32  low 32 bits of the product, or the quotient
- data_exception  out  1  overflow or divide-by-zero, valid with data_resultRDY
- data_resultRDY  out  1  one-cycle completion strobe

## Operation
- States: IDLE, MULT, DIV, DONE.
- Start:
  - At any edge with ctrl_MULT=1, operands latch and the state goes to MULT, from any state.
  - With ctrl_DIV=1 and ctrl_MULT=0, the state goes to DIV.
  - If both are high, MULT wins.
  - A start while in MULT or DIV aborts the current operation and restarts. No RDY is produced for the aborted operation.
- MULT: booth-free shift-add on operand magnitudes.
  - 64-bit product accumulator.
  - Sign is applied at the end: negate if signA XOR signB.
  - data_result = product[31:0].
  - Exception is raised if the signed 64-bit product differs from the sign extension of product[31:0]. Example: -2^31 × -1 gives result 0x80000000, exception 1.
- DIV: restoring division on magnitudes, one quotient bit per iteration.
  - Quotient truncates toward zero; the remainder is discarded.
  - Divisor 0: result 0x00000000, exception 1.
  - -2^31 / -1: result 0x80000000, exception 1.
  - All other cases: exception 0.
- DONE: lasts one cycle.
  - data_result and data_exception update at entry to DONE; data_resultRDY is high during DONE.
  - Next state is IDLE, or MULT/DIV if a start is sampled at that edge.
- data_result and data_exception hold their last completed values until the next completion.

## Timing
- Start sampled at edge E0. Iterations occur at edges E1..E32; the state enters DONE at E32.
- data_resultRDY is high from E32 to E33. Latency is exactly 32 cycles for every operand value, including divide-by-zero.
- Back-to-back: a start sampled at E32+1 (the edge leaving DONE) begins a new operation. Throughput is one result per 33 cycles.
- Reset values: data_result=0, data_exception=0, data_resultRDY=0, state IDLE, counter 0.
- Reset mid-operation: the operation is dropped with no RDY. If reset and ctrl_* are high on the same edge, reset wins.
- Operand inputs are don't-care except at the start edge.

## Structure
- multdiv_pkg holds:
  - state enum (IDLE, MULT, DIV, DONE);
  - WIDTH=32 and ITER=32 constants;
  - counter width localparam (6 bits).
- One sub-module, multdiv_counter: a 6-bit up-counter with synchronous clear, load-on-start and terminal-count output (count==ITER-1). It is used by the FSM to leave MULT/DIV.
- Datapath (accumulator, shift registers, sign fix-up, exception logic) and FSM live in multdiv_unit.

## Test plan
- Reset, then ctrl_MULT with A=7, B=-3 (0xFFFFFFFD) → RDY exactly 32 cycles later, result 0xFFFFFFEB, exception 0, RDY high one cycle only.
- ctrl_MULT with A=0x00010000, B=0x00010000 → result 0x00000000, exception 1.
- ctrl_DIV with A=-7, B=2 → result 0xFFFFFFFD, exception 0.
- ctrl_DIV with A=100, B=7 → 14.
- ctrl_DIV with A=5, B=0 → result 0, exception 1 at cycle 32.
- ctrl_MULT with A=3, B=4, then ctrl_DIV with A=100, B=7 at cycle 10 → no RDY for the multiply; single RDY 32 cycles after the divide start, result 14; ctrl_MULT and ctrl_DIV both high → multiply performed.
- Assert reset at cycle 15 of a multiply → RDY never asserts, outputs read 0. A following ctrl_MULT with A=-2^31, B=-1 → result 0x80000000, exception 1.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT,
    ST_DIV,
    ST_DONE
  } md_state_e;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: clears or loads to zero, counts up while enabled, flags the last iteration.
module multdiv_counter
  import multdiv_pkg::*;
#(
  parameter int ITER = MD_ITER
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic tc
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr || load) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/multdiv_unit.sv
// Sequential signed 32-bit multiply/divide: radix-2 shift-add multiply and restoring divide,
// fixed 32-iteration latency, one-cycle ready strobe with held result and exception.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] data_operandA,
  input  logic signed [WIDTH-1:0] data_operandB,
  input  logic                    ctrl_MULT,
  input  logic                    ctrl_DIV,
  output logic [WIDTH-1:0]        data_result,
  output logic                    data_exception,
  output logic                    data_resultRDY
);

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? -u : u;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] p,
                                                         input logic neg);
    return neg ? -p : p;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] p, input logic neg);
    return neg ? -p : p;
  endfunction

  md_state_e          state_d, state_q;
  logic [2*WIDTH-1:0] acc_d, acc_q;
  logic [WIDTH-1:0]   mag_d, mag_q;
  logic               neg_d, neg_q;
  logic               bzero_d, bzero_q;
  logic [WIDTH-1:0]   result_d, result_q;
  logic               exc_d, exc_q;
  logic               rdy_d, rdy_q;

  logic               start, start_mult, busy, tc;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic               div_ok;
  logic [2*WIDTH-1:0] mul_next, div_next, mul_signed;
  logic [WIDTH-1:0]   quo_mag, div_res;
  logic               mul_exc, div_exc;

  assign start      = ctrl_MULT | ctrl_DIV;
  assign start_mult = ctrl_MULT;
  assign busy       = (state_q == ST_MULT) || (state_q == ST_DIV);

  multdiv_counter #(.ITER(ITER)) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (busy & tc),
    .load  (start),
    .inc   (busy),
    .tc    (tc)
  );

  // acc holds {partial product hi, multiplier} for MULT and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
    mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                         : {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, mag_q};
    div_ok    = (div_shift >= {1'b0, mag_q});
    div_next  = div_ok ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    mul_signed = apply_sign_wide(mul_next, neg_q);
    mul_exc    = (mul_signed[2*WIDTH-1:WIDTH] != {WIDTH{mul_signed[WIDTH-1]}});

    // Only -2^31 / -1 can produce a positive quotient magnitude of 2^31.
    quo_mag = div_next[WIDTH-1:0];
    div_exc = bzero_q | (quo_mag[WIDTH-1] & ~neg_q);
    div_res = bzero_q ? '0 : apply_sign(quo_mag, neg_q);
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    bzero_d  = bzero_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    case (state_q)
      ST_MULT: begin
        acc_d = mul_next;
        if (tc) begin
          state_d  = ST_DONE;
          result_d = mul_signed[WIDTH-1:0];
          exc_d    = mul_exc;
          rdy_d    = 1'b1;
        end
      end
      ST_DIV: begin
        acc_d = div_next;
        if (tc) begin
          state_d  = ST_DONE;
          result_d = div_res;
          exc_d    = div_exc;
          rdy_d    = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A start always wins, aborting any in-flight operation without a completion.
    if (start) begin
      state_d  = start_mult ? ST_MULT : ST_DIV;
      acc_d    = {{WIDTH{1'b0}}, start_mult ? magnitude(data_operandB) : magnitude(data_operandA)};
      mag_d    = start_mult ? magnitude(data_operandA) : magnitude(data_operandB);
      neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      bzero_d  = (data_operandB == '0);
      result_d = result_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      bzero_q  <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      bzero_q  <= bzero_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule
